// File: rtl/abft_checksum_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : abft_checksum_gen_if
//  Description : Bus bundle for the ABFT checksum generator. Carries the
//                element-pair input stream (valid/ready/last + A/B element),
//                the result handshake (out_valid/out_ready), the column and
//                row checksums c1..c4 / r1..r4, the checksum products p1..p4
//                and the framing-error pulse.
//                master : the side that feeds elements and consumes results
//                slave  : the checksum generator itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface abft_checksum_gen_if #(
    parameter int ELEM_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [ELEM_W-1:0] a_elem;
    logic [ELEM_W-1:0] b_elem;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        c1, c2, c3, c4;
    logic [7:0]        r1, r2, r3, r4;
    logic [15:0]       p1, p2, p3, p4;
    logic              frame_err;

    modport master (
        output in_valid, in_last, a_elem, b_elem, out_ready,
        input  in_ready, out_valid,
        input  c1, c2, c3, c4, r1, r2, r3, r4, p1, p2, p3, p4,
        input  frame_err
    );

    modport slave (
        input  in_valid, in_last, a_elem, b_elem, out_ready,
        output in_ready, out_valid,
        output c1, c2, c3, c4, r1, r2, r3, r4, p1, p2, p3, p4,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/abft_checksum_gen.sv
`default_nettype none
// ============================================================================
//  Module      : abft_checksum_gen
//  Description : Consumes a 16-beat row-major frame of (A, B) element pairs
//                of a 4x4 matrix product, builds the column sums of A and the
//                row sums of B, then forms p_k = c_k * r_k over four cycles
//                with one shared 8x8 multiplier and presents the results on a
//                valid/ready handshake.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - abft_checksum_gen_if.slave (input stream, results,
//                       frame_err pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module abft_checksum_gen #(
    parameter int ELEM_W = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    abft_checksum_gen_if.slave  bus
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_mult = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [1:0]  r_mcnt;
    logic [7:0]  r_csum [4];
    logic [7:0]  r_rsum [4];
    logic [7:0]  r_c    [4];
    logic [7:0]  r_r    [4];
    logic [15:0] r_p    [4];
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_frame_err;

    logic        w_accept;
    logic        w_last_idx;
    logic        w_viol;
    logic [1:0]  w_col;
    logic [1:0]  w_row;
    logic [7:0]  w_a_ext;
    logic [7:0]  w_b_ext;
    logic [7:0]  w_csum_upd;
    logic [7:0]  w_rsum_upd;
    logic [15:0] w_prod;

    // in_ready is registered, so it is only ever high in IDLE/LOAD
    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_last_idx = (r_idx == 4'd15);
    // in_last must coincide exactly with beat 15
    assign w_viol     = bus.in_last ^ w_last_idx;
    assign w_col      = r_idx[1:0];
    assign w_row      = r_idx[3:2];
    assign w_a_ext    = {{(8-ELEM_W){1'b0}}, bus.a_elem};
    assign w_b_ext    = {{(8-ELEM_W){1'b0}}, bus.b_elem};

    // First touch of an accumulator in the frame loads instead of adding,
    // which removes the need for a clear cycle between frames.
    assign w_csum_upd = (w_row == 2'd0) ? w_a_ext : r_csum[w_col] + w_a_ext;
    assign w_rsum_upd = (w_col == 2'd0) ? w_b_ext : r_rsum[w_row] + w_b_ext;

    // Shared multiplier, operand selected by the MULT cycle count
    assign w_prod = {8'd0, r_c[r_mcnt]} * {8'd0, r_r[r_mcnt]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_idle;
            r_idx       <= 4'd0;
            r_mcnt      <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_csum[k] <= 8'd0;
                r_rsum[k] <= 8'd0;
                r_c[k]    <= 8'd0;
                r_r[k]    <= 8'd0;
                r_p[k]    <= 16'd0;
            end
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_idle, c_load: begin
                    if (w_accept) begin
                        r_csum[w_col] <= w_csum_upd;
                        r_rsum[w_row] <= w_rsum_upd;
                        if (w_viol) begin
                            // Drop the frame; published outputs are untouched
                            r_frame_err <= 1'b1;
                            r_state     <= c_idle;
                            r_idx       <= 4'd0;
                            r_in_ready  <= 1'b1;
                        end else if (w_last_idx) begin
                            // Publish sums including this final beat
                            for (int k = 0; k < 4; k++) begin
                                r_c[k] <= (2'(k) == w_col) ? w_csum_upd : r_csum[k];
                                r_r[k] <= (2'(k) == w_row) ? w_rsum_upd : r_rsum[k];
                            end
                            r_state    <= c_mult;
                            r_idx      <= 4'd0;
                            r_mcnt     <= 2'd0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_state    <= c_load;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        // Also raises in_ready on the first edge after reset
                        r_in_ready <= 1'b1;
                    end
                end
                c_mult: begin
                    r_p[r_mcnt] <= w_prod;
                    r_mcnt      <= r_mcnt + 2'd1;
                    if (r_mcnt == 2'd3) begin
                        r_state     <= c_done;
                        r_out_valid <= 1'b1;
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_state     <= c_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_idle;
                    r_idx      <= 4'd0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.c1 = r_c[0];
    assign bus.c2 = r_c[1];
    assign bus.c3 = r_c[2];
    assign bus.c4 = r_c[3];
    assign bus.r1 = r_r[0];
    assign bus.r2 = r_r[1];
    assign bus.r3 = r_r[2];
    assign bus.r4 = r_r[3];
    assign bus.p1 = r_p[0];
    assign bus.p2 = r_p[1];
    assign bus.p3 = r_p[2];
    assign bus.p4 = r_p[3];

endmodule
`default_nettype wire
